// File: rtl/spi_arbiter_pkg.sv
// Shared types and helpers for the SPI client arbiter and its round-robin picker.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    SPI_ARBITER_IDLE     = 2'd0,
    SPI_ARBITER_SEND     = 2'd1,
    SPI_ARBITER_WAIT_RSP = 2'd2,
    SPI_ARBITER_RESPOND  = 2'd3
  } spi_arbiter_state_t;

  // Response sideband registered alongside the response byte.
  typedef struct packed {
    logic tlast;
    logic tuser;
  } spi_arbiter_rsp_flags_t;

  // Index that sits 'offset' places after 'base', wrapping at n (base < n, offset <= n).
  function automatic int unsigned rr_next_index(input int unsigned base,
                                                input int unsigned offset,
                                                input int unsigned n);
    int unsigned sum;
    sum = base + offset;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after i_last_grant, wrapping.
module spi_arbiter_rr_picker
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_found
);

  // Offsets 1..NUM_REQ visit every client once, ending on the previous winner.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    o_winner = '0;
    o_found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = rr_next_index(32'(i_last_grant), k, NUM_REQ);
      if (!o_found && i_req[IDX_W'(idx)]) begin
        o_found  = 1'b1;
        o_winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master byte engine between several clients, one whole
// tlast-framed transaction per grant, rotating round-robin.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS     = 4,
  parameter int unsigned TRANSFER_WIDTH     = 8,
  parameter int unsigned RSP_TIMEOUT_CYCLES = 4096
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_REQUESTERS*TRANSFER_WIDTH-1:0] req_tdata,
  input  logic [NUM_REQUESTERS-1:0]                req_tvalid,
  input  logic [NUM_REQUESTERS-1:0]                req_tlast,
  output logic [NUM_REQUESTERS-1:0]                req_tready,
  output logic [TRANSFER_WIDTH-1:0]                rsp_tdata,
  output logic [NUM_REQUESTERS-1:0]                rsp_tvalid,
  output logic                                     rsp_tlast,
  output logic                                     rsp_tuser,
  input  logic [NUM_REQUESTERS-1:0]                rsp_tready,
  output logic [TRANSFER_WIDTH-1:0]                mosi_tdata,
  output logic                                     mosi_tvalid,
  input  logic                                     mosi_tready,
  input  logic [TRANSFER_WIDTH-1:0]                miso_tdata,
  input  logic                                     miso_tvalid,
  output logic                                     miso_tready,
  output logic [$clog2(NUM_REQUESTERS)-1:0]        grant_id,
  output logic                                     busy
);

  localparam int unsigned N   = NUM_REQUESTERS;
  localparam int unsigned W   = TRANSFER_WIDTH;
  localparam int unsigned IDW = $clog2(NUM_REQUESTERS);
  localparam int unsigned CW  = $clog2(RSP_TIMEOUT_CYCLES) + 1;

  localparam logic [IDW-1:0] LAST_IDX     = IDW'(N - 1);
  localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(RSP_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX      = {CW{1'b1}};

  spi_arbiter_state_t     r_state, w_state_nxt;
  logic [IDW-1:0]         r_grant, w_grant_nxt;
  logic [IDW-1:0]         r_last_grant, w_last_grant_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_last_flag, w_last_flag_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [W-1:0]           r_rsp_tdata, w_rsp_tdata_nxt;
  spi_arbiter_rsp_flags_t r_rsp_flags, w_rsp_flags_nxt;

  logic [W-1:0]   w_req_data [N];
  logic           w_sel_tvalid;
  logic [W-1:0]   w_sel_tdata;
  logic           w_sel_tlast;
  logic [IDW-1:0] w_winner;
  logic           w_found;

  for (genvar g = 0; g < N; g++) begin : g_req_slice
    assign w_req_data[g] = req_tdata[g*W +: W];
  end

  assign w_sel_tvalid = req_tvalid[r_grant];
  assign w_sel_tdata  = w_req_data[r_grant];
  assign w_sel_tlast  = req_tlast[r_grant];

  spi_arbiter_rr_picker #(
    .NUM_REQ (N),
    .IDX_W   (IDW)
  ) u_rr_picker (
    .i_req        (req_tvalid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_found      (w_found)
  );

  // State and datapath registers; reset drops any byte in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= SPI_ARBITER_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_IDX;
      r_busy       <= 1'b0;
      r_last_flag  <= 1'b0;
      r_cnt        <= '0;
      r_rsp_tdata  <= '0;
      r_rsp_flags  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_last_flag  <= w_last_flag_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rsp_tdata  <= w_rsp_tdata_nxt;
      r_rsp_flags  <= w_rsp_flags_nxt;
    end
  end

  // Next-state logic plus the stream handshakes that follow the granted client.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_busy_nxt       = r_busy;
    w_last_flag_nxt  = r_last_flag;
    w_cnt_nxt        = r_cnt;
    w_rsp_tdata_nxt  = r_rsp_tdata;
    w_rsp_flags_nxt  = r_rsp_flags;
    req_tready       = '0;
    rsp_tvalid       = '0;
    mosi_tdata       = '0;
    mosi_tvalid      = 1'b0;
    miso_tready      = 1'b0;

    unique case (r_state)
      SPI_ARBITER_IDLE: begin
        if (w_found) begin
          w_grant_nxt      = w_winner;
          w_last_grant_nxt = w_winner;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = SPI_ARBITER_SEND;
        end
      end

      SPI_ARBITER_SEND: begin
        req_tready[r_grant] = mosi_tready;
        mosi_tdata          = w_sel_tdata;
        mosi_tvalid         = w_sel_tvalid;
        if (w_sel_tvalid && mosi_tready) begin
          w_last_flag_nxt = w_sel_tlast;
          w_cnt_nxt       = '0;
          w_state_nxt     = SPI_ARBITER_WAIT_RSP;
        end
      end

      SPI_ARBITER_WAIT_RSP: begin
        miso_tready = 1'b1;
        // A byte arriving on the timeout cycle still counts as a real response.
        if (miso_tvalid) begin
          w_rsp_tdata_nxt       = miso_tdata;
          w_rsp_flags_nxt.tuser = 1'b0;
          w_rsp_flags_nxt.tlast = r_last_flag;
          w_state_nxt           = SPI_ARBITER_RESPOND;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_rsp_tdata_nxt       = '0;
          w_rsp_flags_nxt.tuser = 1'b1;
          w_rsp_flags_nxt.tlast = r_last_flag;
          w_state_nxt           = SPI_ARBITER_RESPOND;
        end
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      SPI_ARBITER_RESPOND: begin
        rsp_tvalid[r_grant] = 1'b1;
        if (rsp_tready[r_grant]) begin
          if (r_last_flag) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = SPI_ARBITER_IDLE;
          end else begin
            w_state_nxt = SPI_ARBITER_SEND;
          end
        end
      end

      default: w_state_nxt = SPI_ARBITER_IDLE;
    endcase
  end

  assign rsp_tdata = r_rsp_tdata;
  assign rsp_tlast = r_rsp_flags.tlast;
  assign rsp_tuser = r_rsp_flags.tuser;
  assign grant_id  = r_grant;
  assign busy      = r_busy;

endmodule
